// File: rtl/fb_axi_writer_if.sv
// AXI4-Lite write-channel bundle used by fb_axi_writer.
//   AW: m_axi_awaddr, m_axi_awvalid (master -> slave), m_axi_awready (slave -> master)
//   W : m_axi_wdata, m_axi_wstrb, m_axi_wvalid (master -> slave), m_axi_wready (slave -> master)
//   B : m_axi_bresp, m_axi_bvalid (slave -> master), m_axi_bready (master -> slave)
interface fb_axi_writer_if;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    modport master (
        output m_axi_awaddr, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/fb_axi_writer.sv
// Framebuffer pixel writer: turns single-pixel requests from a line drawer into
// single-beat AXI4-Lite writes, queued through a small pixel FIFO.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   fb_base             framebuffer byte base address, sampled per pixel at push
//   fb_addr, fb_data    pixel byte offset and value from the drawer
//   w_en                level request; only a 0->1 transition requests a pixel
//   axi_master_state    00 IDLE, 01 ADDR, 10 RESP, 11 ERROR
//   axi_master_awready  sticky "pixel accepted" flag back to the drawer
//   err_count           saturating count of non-OKAY write responses
//   drop_count          saturating count of pixels dropped on a full FIFO
//   axi                 AXI4-Lite write channels (master modport)
module fb_axi_writer #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       fb_base,
    input  logic [15:0]       fb_addr,
    input  logic [7:0]        fb_data,
    input  logic              w_en,
    output logic [1:0]        axi_master_state,
    output logic              axi_master_awready,
    output logic [7:0]        err_count,
    output logic [7:0]        drop_count,
    fb_axi_writer_if.master   axi
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [1:0]      RespOkay = 2'b00;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StAddr  = 2'b01,
        StResp  = 2'b10,
        StError = 2'b11
    } state_e;

    // ------------------------------------------------------------------
    // Request edge detection
    // ------------------------------------------------------------------
    logic w_en_q;
    logic armed_q;
    logic req_edge;

    // armed_q only rises once w_en has been seen low, so a level already high
    // when reset releases is not mistaken for a fresh request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            w_en_q <= w_en;
            if (!w_en) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign req_edge = w_en & ~w_en_q & armed_q;

    // ------------------------------------------------------------------
    // Pixel FIFO: entries are {byte address, pixel}
    // ------------------------------------------------------------------
    logic [39:0]     mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic            fifo_full, fifo_empty;
    logic            push, pop, drop;
    logic [31:0]     push_addr;

    assign fifo_full  = (count_q == CntFull);
    assign fifo_empty = (count_q == '0);
    assign push       = req_edge & ~fifo_full;
    assign drop       = req_edge & fifo_full;
    assign push_addr  = fb_base + {16'h0000, fb_addr};

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {push_addr, fb_data};
        end
    end

    // ------------------------------------------------------------------
    // AXI write FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  err_q, err_d;
    logic [7:0]  drop_q, drop_d;
    logic        accepted_q, accepted_d;
    logic        aw_hs, w_hs;

    assign aw_hs = awvalid_q & axi.m_axi_awready;
    assign w_hs  = wvalid_q & axi.m_axi_wready;

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_d     = err_q;
        pop       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop              = 1'b1;
                    {addr_d, data_d} = mem[rd_ptr_q];
                    awvalid_d        = 1'b1;
                    wvalid_d         = 1'b1;
                    state_d          = StAddr;
                end
            end
            StAddr: begin
                // AW and W complete independently, in either order.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (axi.m_axi_bvalid) begin
                    if (axi.m_axi_bresp == RespOkay) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StError;
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                    end
                end
            end
            StError: begin
                // Failed pixel is not retried.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // The accepted flag tracks the most recent request: it sets on an AW
    // handshake only when nothing newer is still queued, and a new request
    // edge always wins. A dropped pixel is therefore acknowledged once the
    // older queued pixels have drained, so the drawer never stalls forever.
    always_comb begin
        accepted_d = accepted_q;
        if (req_edge) begin
            accepted_d = 1'b0;
        end else if (aw_hs && fifo_empty) begin
            accepted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= '0;
            drop_q     <= '0;
            accepted_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
            accepted_q <= accepted_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Report ADDR while a queued pixel is about to be popped out of IDLE.
    assign axi_master_state   = ((state_q == StIdle) && !fifo_empty) ? StAddr : state_q;
    assign axi_master_awready = accepted_q;
    assign err_count          = err_q;
    assign drop_count         = drop_q;

    assign axi.m_axi_awaddr  = {addr_q[31:2], 2'b00};
    assign axi.m_axi_awvalid = awvalid_q;
    assign axi.m_axi_wdata   = {4{data_q}};
    assign axi.m_axi_wstrb   = 4'b0001 << addr_q[1:0];
    assign axi.m_axi_wvalid  = wvalid_q;
    assign axi.m_axi_bready  = (state_q == StResp);

endmodule

// File: doc/fb_axi_writer.md
FB_AXI_WRITER -- requirements
Module: fb_axi_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, pixel FIFO entries (power of two, 2..8).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous assert, active-low reset.
- fb_base  in  32  framebuffer byte base address.
- fb_addr  in  16  pixel offset from line drawer.
- fb_data  in  8  pixel value.
- w_en  in  1  write request; level, held several cycles per pixel.
- axi_master_state  out  2  00 IDLE, 01 ADDR, 10 RESP, 11 ERROR.
- axi_master_awready  out  1  sticky "pixel accepted" flag for drawer.
- m_axi_awaddr  out  32;  m_axi_awvalid  out  1;  m_axi_awready  in  1.
- m_axi_wdata  out  32;  m_axi_wstrb  out  4;  m_axi_wvalid  out  1;  m_axi_wready  in  1.
- m_axi_bresp  in  2;  m_axi_bvalid  in  1;  m_axi_bready  out  1.
- err_count  out  8  saturating count of non-OKAY responses.
- drop_count  out  8  saturating count of pixels dropped on FIFO full.

Function
REQ-003 SHALL register w_en and treat only a 0->1 transition as a pixel request; holding w_en high SHALL NOT generate further requests.
REQ-004 On a request edge, SHALL push {fb_base + zero-extended fb_addr, fb_data} sampled in that same cycle into the FIFO.
REQ-005 If the FIFO is full at a request edge, SHALL discard the pixel and increment drop_count (saturate at 255).
REQ-006 SHALL clear axi_master_awready in the cycle after a request edge; SHALL set it on the AW handshake of that pixel; SHALL hold it until the next request edge.
REQ-007 FSM IDLE: FIFO non-empty -> ADDR; SHALL pop the head and assert awvalid and wvalid together in the next cycle.
REQ-008 ADDR: each of awvalid and wvalid SHALL drop independently on its own handshake; both done -> RESP; the order of AW and W handshakes is free.
REQ-009 m_axi_awaddr SHALL be the byte address with bits [1:0] forced to 0.
REQ-010 m_axi_wdata SHALL be fb_data replicated four times.
REQ-011 m_axi_wstrb SHALL be 4'b0001 shifted left by address[1:0].
REQ-012 RESP: bready SHALL be 1; on bvalid with bresp == 00 -> IDLE; on bvalid with bresp != 00 -> ERROR and increment err_count (saturate at 255).
REQ-013 ERROR SHALL last exactly one cycle, then -> IDLE; the pixel SHALL NOT be retried.
REQ-014 axi_master_state SHALL equal the FSM state, except that it SHALL report ADDR (not IDLE) while the FSM is IDLE and the FIFO is non-empty.
REQ-015 Once asserted, awvalid and wvalid SHALL remain asserted with stable payload until their handshakes complete.
REQ-016 A push and a pop in the same cycle SHALL both take effect.
REQ-017 A push to an empty FIFO SHALL be poppable in the following cycle; minimum request-edge-to-awvalid latency SHALL be 2 cycles.
REQ-018 fb_base SHALL be sampled per pixel at push time; a change mid-transaction SHALL NOT affect in-flight addresses.

Reset
REQ-019 rst_n low SHALL immediately and asynchronously force the FSM to IDLE and empty the FIFO.
REQ-020 rst_n low SHALL force awvalid = wvalid = bready = 0, err_count = drop_count = 0, axi_master_awready = 0, and the registered w_en = 0.
REQ-021 Reset mid-transaction SHALL abandon the transaction without waiting for a response.
REQ-022 After rst_n deasserts, a w_en already high SHALL NOT count as an edge until it has been low for at least one cycle.

Verification
REQ-023 Scenario: fb_base = 0x4000_0000, fb_addr = 0x1235, fb_data = 0xA5, w_en high for 4 cycles, slave always ready, bresp = 00 -> exactly one write; awaddr = 0x4000_1234, wdata = 0xA5A5A5A5, wstrb = 0010; axi_master_awready = 1; state returns to 00.
REQ-024 Scenario: awready delayed 5 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid is held with a stable address; RESP is entered only after the AW handshake.
REQ-025 Scenario: bresp = 10 on one pixel -> state 11 for one cycle, err_count = 1, no retry, next pixel proceeds normally.
REQ-026 Scenario: 4 request edges with awready tied low, FIFO_DEPTH = 2 -> drop_count = 1; the remaining pixels drain in order once awready rises.
REQ-027 Scenario: rst_n pulsed low while in RESP with 1 entry queued -> all outputs at reset values, FIFO empty, no write issued after release.
REQ-028 Scenario: drive the module from the line drawer for the line (0,0)->(7,3) -> exactly 8 writes with the correct addresses, and no deadlock.
